// File: rtl/branch_predictor.sv
// Bimodal direction predictor with a direct-mapped BTB.
// Lookup is combinational from registered state; training is applied on the rising edge.
module branch_predictor #(
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned TAG_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pred_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic        upd_is_br,
  input  logic [31:0] upd_pc,
  input  logic        upd_br_en,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  output logic        upd_mispredict,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int unsigned Entries = 1 << IDX_BITS;

  logic                valid_q  [Entries];
  logic [TAG_BITS-1:0] tag_q    [Entries];
  logic [29:0]         target_q [Entries];
  logic [1:0]          ctr_q    [Entries];

  logic [IDX_BITS-1:0] pred_idx, upd_idx;
  logic [TAG_BITS-1:0] pred_tag, upd_tag;

  assign pred_idx = pred_pc[IDX_BITS+1:2];
  assign pred_tag = pred_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign upd_idx  = upd_pc[IDX_BITS+1:2];
  assign upd_tag  = upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

  // Lookup: no bypass from a same-cycle update.
  always_comb begin
    pred_hit    = valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);
    pred_taken  = pred_hit && ctr_q[pred_idx][1];
    pred_target = pred_taken ? {target_q[pred_idx], 2'b00} : pred_pc + 32'd4;
  end

  logic upd_qual, upd_hit;

  assign upd_qual       = upd_valid && upd_is_br;
  assign upd_hit        = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_mispredict = upd_qual && (upd_br_en != upd_pred_taken);

  logic                wr_en;
  logic                valid_d;
  logic [TAG_BITS-1:0] tag_d;
  logic [29:0]         target_d;
  logic [1:0]          ctr_d;

  always_comb begin
    wr_en    = 1'b0;
    valid_d  = valid_q[upd_idx];
    tag_d    = tag_q[upd_idx];
    target_d = target_q[upd_idx];
    ctr_d    = ctr_q[upd_idx];
    if (upd_qual) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (upd_br_en) begin
          ctr_d    = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
          target_d = upd_target[31:2];
        end else begin
          ctr_d = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_br_en) begin
        // Allocate on a taken miss, evicting whatever shared the index.
        wr_en    = 1'b1;
        valid_d  = 1'b1;
        tag_d    = upd_tag;
        target_d = upd_target[31:2];
        ctr_d    = 2'b10;
      end
    end
  end

  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (upd_qual && (branch_count_q != 32'hFFFF_FFFF)) begin
      branch_count_d = branch_count_q + 32'd1;
    end
    if (upd_mispredict && (mispredict_count_q != 32'hFFFF_FFFF)) begin
      mispredict_count_d = mispredict_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < Entries; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (wr_en) begin
        valid_q[upd_idx]  <= valid_d;
        tag_q[upd_idx]    <= tag_d;
        target_q[upd_idx] <= target_d;
        ctr_q[upd_idx]    <= ctr_d;
      end
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: stimulus queues expectations, a negedge monitor checks them.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pred_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid, upd_is_br, upd_br_en, upd_pred_taken;
  logic [31:0] upd_pc, upd_target;
  logic        upd_mispredict;
  logic [31:0] branch_count, mispredict_count;

  branch_predictor #(.IDX_BITS(6), .TAG_BITS(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pred_pc          (pred_pc),
    .pred_hit         (pred_hit),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .upd_valid        (upd_valid),
    .upd_is_br        (upd_is_br),
    .upd_pc           (upd_pc),
    .upd_br_en        (upd_br_en),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .upd_mispredict   (upd_mispredict),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          c_pred;
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
    bit          c_mis;
    logic        mis;
    bit          c_cnt;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic cmp(input string name, input string field, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s.%s: got %h, required %h", name, field, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.c_pred) begin
        cmp(e.name, "pred_hit", {31'd0, pred_hit}, {31'd0, e.hit});
        cmp(e.name, "pred_taken", {31'd0, pred_taken}, {31'd0, e.taken});
        cmp(e.name, "pred_target", pred_target, e.tgt);
      end
      if (e.c_mis) cmp(e.name, "upd_mispredict", {31'd0, upd_mispredict}, {31'd0, e.mis});
      if (e.c_cnt) begin
        cmp(e.name, "branch_count", branch_count, e.bc);
        cmp(e.name, "mispredict_count", mispredict_count, e.mc);
      end
    end
  end

  task automatic idle();
    upd_valid = 1'b0; upd_is_br = 1'b0; upd_pc = '0; upd_br_en = 1'b0;
    upd_target = '0; upd_pred_taken = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic ben, input logic [31:0] tgt,
                     input logic pt);
    upd_valid = 1'b1; upd_is_br = 1'b1; upd_pc = pc; upd_br_en = ben;
    upd_target = tgt; upd_pred_taken = pt;
  endtask

  task automatic exp_pred(input logic [31:0] pc, input logic h, input logic t,
                          input logic [31:0] tgt);
    pred_pc = pc; cur.c_pred = 1'b1; cur.hit = h; cur.taken = t; cur.tgt = tgt;
  endtask

  task automatic exp_mis(input logic m);
    cur.c_mis = 1'b1; cur.mis = m;
  endtask

  task automatic exp_cnt(input logic [31:0] bc, input logic [31:0] mc);
    cur.c_cnt = 1'b1; cur.bc = bc; cur.mc = mc;
  endtask

  // Queue this cycle's expectation, then advance to just after the next rising edge.
  task automatic tick(input string name);
    cur.name = name;
    exp_q.push_back(cur);
    @(posedge clk);
    #1;
    cur = '{name: "", c_pred: 1'b0, hit: 1'b0, taken: 1'b0, tgt: '0, c_mis: 1'b0,
            mis: 1'b0, c_cnt: 1'b0, bc: '0, mc: '0};
    idle();
  endtask

  initial begin
    cur = '{name: "", c_pred: 1'b0, hit: 1'b0, taken: 1'b0, tgt: '0, c_mis: 1'b0,
            mis: 1'b0, c_cnt: 1'b0, bc: '0, mc: '0};
    rst_n = 1'b0;
    pred_pc = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    exp_pred(32'h100, 0, 0, 32'h104); exp_cnt(0, 0); exp_mis(0); tick("reset_state");

    upd(32'h100, 1, 32'h80, 0);
    exp_pred(32'h100, 0, 0, 32'h104); exp_mis(1); exp_cnt(0, 0); tick("alloc_cycle");
    exp_pred(32'h100, 1, 1, 32'h80); exp_cnt(1, 1); tick("after_alloc");

    upd(32'h100, 1, 32'h80, 1); exp_mis(0); tick("taken_2");
    upd(32'h100, 1, 32'h80, 1); exp_mis(0); exp_cnt(2, 1); tick("taken_3");
    upd(32'h100, 0, 32'h0, 1);
    exp_pred(32'h100, 1, 1, 32'h80); exp_mis(1); exp_cnt(3, 1); tick("nt_1");
    exp_pred(32'h100, 1, 1, 32'h80); exp_cnt(4, 2); tick("ctr_10");
    upd(32'h100, 0, 32'h0, 1); exp_mis(1); tick("nt_2");
    exp_pred(32'h100, 1, 0, 32'h104); exp_cnt(5, 3); tick("ctr_01");

    // Drive to 00, saturate, then retrain with new targets.
    upd(32'h100, 0, 32'h999, 0); exp_mis(0); tick("nt_3");
    upd(32'h100, 0, 32'h0, 0); exp_mis(0); tick("nt_sat");
    upd(32'h100, 1, 32'h300, 0); exp_mis(1); tick("t_from_00");
    exp_pred(32'h100, 1, 0, 32'h104); exp_cnt(8, 4); tick("ctr_01_again");
    upd(32'h100, 1, 32'h340, 0); tick("t_to_10");
    exp_pred(32'h100, 1, 1, 32'h340); exp_cnt(9, 5); tick("new_target");

    // 0x500 shares index 0 with 0x100 under a different tag.
    upd(32'h500, 1, 32'h900, 0);
    exp_pred(32'h100, 1, 1, 32'h340); exp_mis(1); tick("alias_alloc");
    exp_pred(32'h100, 0, 0, 32'h104); exp_cnt(10, 6); tick("alias_evicted");
    exp_pred(32'h500, 1, 1, 32'h900); tick("alias_new");

    upd(32'h200, 1, 32'h240, 0);
    exp_pred(32'h200, 0, 0, 32'h204); exp_mis(1); tick("same_cycle");
    exp_pred(32'h200, 1, 1, 32'h240); exp_cnt(11, 7); tick("next_cycle");

    upd(32'h200, 0, 32'h0, 1); upd_valid = 1'b0; exp_mis(0); tick("invalid_ignored");
    upd(32'h200, 0, 32'h0, 1); upd_is_br = 1'b0; exp_mis(0); tick("not_br_ignored");
    exp_pred(32'h200, 1, 1, 32'h240); exp_cnt(11, 7); tick("unchanged");

    exp_pred(32'hFFFF_FFFC, 0, 0, 32'h0); tick("pc_wrap");
    upd(32'h600, 0, 32'h0, 1); exp_mis(1); tick("miss_nt");
    exp_pred(32'h600, 0, 0, 32'h604); exp_cnt(12, 8); tick("miss_nt_no_alloc");

    rst_n = 1'b0;
    upd(32'h300, 1, 32'h50, 0); exp_mis(1); tick("reset_vs_update");
    rst_n = 1'b1;
    exp_pred(32'h200, 0, 0, 32'h204); exp_cnt(0, 0); tick("after_reset_200");
    exp_pred(32'h300, 0, 0, 32'h304); exp_cnt(0, 0); tick("after_reset_300");
    exp_pred(32'h500, 0, 0, 32'h504); tick("after_reset_500");

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
